wb_ddr2_rr_arbiter: RTL and testbench
=====================================

# wb_ddr2_rr_arbiter

Parameterised round-robin Wishbone B3 arbiter that shares the single DDR2 controller Wishbone slave port between NUM_MASTERS bus masters (instruction bus, data bus, debug/DMA). It sits between the masters and the DDR2 interface. It holds a grant for a master's whole cycle, including classic and incrementing bursts. A watchdog aborts a granted cycle that stalls without acknowledge, so one hung slave transaction cannot lock out the other masters.

## Interface
Parameters:
- NUM_MASTERS, 3: number of requesting masters, range 2–8.
- TIMEOUT, 1024: cycles allowed with stb high and no ack before abort. 0 disables the watchdog.

Ports. Master buses are flattened: master k occupies slice [k*W +: W].
- wb_clk  in  1  sole clock. All logic is on the rising edge.
- wb_rst_n  in  1  synchronous reset, active-low.
- wbm_adr_i  in  32*N  master addresses.
- wbm_dat_i  in  32*N  master write data.
- wbm_sel_i  in  4*N  byte selects.
- wbm_cti_i  in  3*N  cycle type.
- wbm_bte_i  in  2*N  burst type.
- wbm_cyc_i, wbm_stb_i, wbm_we_i  in  N each  per-master strobes.
- wbm_dat_o  out  32  read data, broadcast to all masters.
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  N each  per-master terminations. rty is tied to 0.
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o, wbs_we_o  out  to the DDR2 slave.
- wbs_dat_i  in  32  and  wbs_ack_i  in  1  from the slave.
- arb_grant_o  out  N  one-hot current grant. All zero means idle.
- arb_timeout_o  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States:
  - IDLE: no grant, all slave outputs 0.
  - BUSY: one master granted, its bus passed through.
  - ABORT: the master has been terminated with err; waiting for it to release cyc.
- IDLE → BUSY: when any wbm_cyc_i is high, grant the first requester found searching from (last+1) mod N upward with wrap. Write grant and last. last resets to N-1, so master 0 wins the first contention.
- BUSY → IDLE: when the granted master's cyc is low. The grant clears on the next edge.
- BUSY → ABORT: when the watchdog fires. wbm_err_o[k] pulses for one cycle, ack is suppressed in that cycle, and wbs_cyc_o/wbs_stb_o go low from the next cycle.
- ABORT → IDLE: when the granted master's cyc is low.
- Muxing:
  - Slave outputs equal the granted master's signals in BUSY. In IDLE and ABORT all slave outputs are 0.
  - wbm_ack_o[k] = wbs_ack_i & grant[k] & (state == BUSY).
- Watchdog counter:
  - Clears on grant and on every wbs_ack_i.
  - Increments each BUSY cycle while the granted stb is high.
  - Fires when the count equals TIMEOUT-1 and wbs_ack_i is low. An ack in the same cycle wins and no err is issued.
  - The counter saturates and never wraps.
  - Width is clog2(TIMEOUT+1).
- Simultaneous requests are resolved purely by rotation. A master that re-asserts cyc in the idle cycle after its own release ranks last when others are requesting.
- Reset mid-cycle: the state goes to IDLE, the grant and all outputs go to 0 on the next edge, and no err is produced. Masters must restart their cycles.

## Timing
- Reset values: arb_grant_o=0, arb_timeout_o=0, wbm_ack/err/rty=0, all wbs_* outputs=0, state IDLE, last=N-1, counter=0.
- Grant latency:
  - cyc is seen in IDLE at edge t.
  - grant and wbs_cyc_o are valid after edge t, so the slave sees the request in cycle t+1.
- Data path: ack, err and read data pass combinationally, with no added latency per beat. Bursts run at slave speed.
- Release: the granted cyc is sampled low at edge t and state is IDLE after t. The next grant can be issued at edge t+1, giving a minimum one-cycle bus gap between owners.
- No combinational path exists from wbm_cyc_i to arb_grant_o. The grant is always registered.

## Structure
- Shared package (orpsoc defines include):
  - Wishbone CTI and BTE constants.
  - Arbiter state encodings ARB_IDLE, ARB_BUSY, ARB_ABORT.
  - The clog2 function.
- One sub-module, wb_rr_pick: combinational round-robin priority select taking a request vector and a last index, returning a one-hot grant and an index. It is reused by other shared-bus arbiters.

## Test plan
- Single master: master 1 performs a 4-beat incrementing read (cti 010…111) with the slave acking each cycle → grant=3'b010 one cycle after cyc. 4 acks reach master 1 only. Masters 0 and 2 see ack=0.
- Contention: all three masters raise cyc together after reset, each doing one single write → grant order 001, 010, 100, with exactly one idle cycle between owners.
- Rotation fairness: master 0 re-requests immediately after its release while master 2 is waiting → master 2 is granted next, then master 0.
- Timeout: TIMEOUT=8, the slave never acks → wbm_err_o pulses for one cycle on the 8th stb cycle, together with arb_timeout_o. wbs_cyc_o is 0 the following cycle. The state returns to IDLE after the master drops cyc.
- Ack at the boundary: TIMEOUT=8, the slave acks exactly on the 8th cycle → ack is delivered, no err, and the counter clears.
- Reset mid-burst: wb_rst_n is driven low during beat 2 of a master-2 burst → the next cycle shows all outputs 0 and the grant at 0. After reset, master 0 wins a three-way contention.

Source files
------------

// File: rtl/wb_ddr2_rr_arbiter_pkg.sv
// rtl/wb_ddr2_rr_arbiter_pkg.sv - shared Wishbone constants, arbiter states and clog2
package wb_ddr2_rr_arbiter_pkg;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_CONST   = 3'b001;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;

  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
  localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
  localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
  localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational round-robin select starting after the last winner
module wb_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] rot;

  // rot[j] is the request of master (last+1+j) mod N; the lowest set bit wins
  always_comb begin
    rot   = {req, req} >> (int'(last) + 1);
    grant = '0;
    idx   = last;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        idx   = IW'((int'(last) + 1 + j) % N);
        grant = N'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/wb_ddr2_rr_arbiter.sv
// rtl/wb_ddr2_rr_arbiter.sv - round-robin Wishbone arbiter in front of the DDR2 slave port
module wb_ddr2_rr_arbiter
  import wb_ddr2_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst_n,
  input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  output logic [31:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic                      wbs_we_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  output logic [NUM_MASTERS-1:0]    arb_grant_o,
  output logic                      arb_timeout_o
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = (clog2(N) < 1) ? 1 : clog2(N);
  localparam int CW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_FIRE = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t    state, state_nxt;
  logic [N-1:0]  grant, pick_grant;
  logic [IW-1:0] last, pick_idx;
  logic [CW-1:0] cnt;
  logic          g_cyc, g_stb, busy, fire;

  wb_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (wbm_cyc_i),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // last always holds the index of the current owner while a grant is held
  assign g_cyc       = wbm_cyc_i[last];
  assign g_stb       = wbm_stb_i[last];
  assign wbm_dat_o   = wbs_dat_i;
  assign wbm_rty_o   = '0;
  assign arb_grant_o = grant;

  always_comb begin
    state_nxt = state;
    busy      = (state == ARB_BUSY);
    fire      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|wbm_cyc_i) state_nxt = ARB_BUSY;
      end
      ARB_BUSY: begin
        fire = (TIMEOUT != 0) && g_cyc && g_stb && !wbs_ack_i && (cnt == CNT_FIRE);
        if (!g_cyc)    state_nxt = ARB_IDLE;
        else if (fire) state_nxt = ARB_ABORT;
      end
      ARB_ABORT: begin
        if (!g_cyc) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase

    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    if (busy) begin
      wbs_adr_o = wbm_adr_i[last*32 +: 32];
      wbs_dat_o = wbm_dat_i[last*32 +: 32];
      wbs_sel_o = wbm_sel_i[last*4 +: 4];
      wbs_cti_o = wbm_cti_i[last*3 +: 3];
      wbs_bte_o = wbm_bte_i[last*2 +: 2];
      wbs_cyc_o = g_cyc;
      wbs_stb_o = g_stb;
      wbs_we_o  = wbm_we_i[last];
    end

    wbm_ack_o     = (busy && wbs_ack_i && !fire) ? grant : '0;
    wbm_err_o     = fire ? grant : '0;
    arb_timeout_o = fire;
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state <= ARB_IDLE;
      grant <= '0;
      last  <= IW'(N - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && |wbm_cyc_i) begin
        grant <= pick_grant;
        last  <= pick_idx;
        cnt   <= '0;
      end else if (state_nxt == ARB_IDLE) begin
        grant <= '0;
      end
      // watchdog saturates instead of wrapping so a disabled or huge limit stays inert
      if (state == ARB_BUSY) begin
        if (wbs_ack_i)                  cnt <= '0;
        else if (g_stb && cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_ddr2_rr_arbiter.sv
// tb/tb_wb_ddr2_rr_arbiter.sv - self-checking bench for the DDR2 round-robin arbiter
module tb_wb_ddr2_rr_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;

  logic            wb_clk = 1'b0;
  logic            wb_rst_n;
  logic [32*N-1:0] wbm_adr_i, wbm_dat_i;
  logic [4*N-1:0]  wbm_sel_i;
  logic [3*N-1:0]  wbm_cti_i;
  logic [2*N-1:0]  wbm_bte_i;
  logic [N-1:0]    wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [31:0]     wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0]     wbs_adr_o, wbs_dat_o;
  logic [3:0]      wbs_sel_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic            wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [31:0]     wbs_dat_i;
  logic            wbs_ack_i;
  logic [N-1:0]    arb_grant_o;
  logic            arb_timeout_o;

  int n_checks = 0;
  int n_fail   = 0;
  int last_m;
  int m_total[N];
  int m_left[N];
  logic [31:0] m_adr[N];
  logic [31:0] m_wdat[N];
  logic        m_we[N];

  wb_ddr2_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
    .arb_grant_o(arb_grant_o), .arb_timeout_o(arb_timeout_o)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  function automatic logic [2:0] exp_cti(input int k);
    if (m_total[k] == 1) return 3'b000;
    return (m_left[k] > 1) ? 3'b010 : 3'b111;
  endfunction

  task automatic idle_masters();
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_cti_i = '0;
    wbm_bte_i = '0; wbm_cyc_i = '0; wbm_stb_i = '0; wbm_we_i  = '0;
  endtask

  task automatic drive_master(input int k, input logic on);
    wbm_cyc_i[k] = on;
    wbm_stb_i[k] = on;
    wbm_cti_i[k*3 +: 3] = on ? exp_cti(k) : 3'b000;
  endtask

  task automatic launch(input int k, input int fixed_beats);
    m_total[k] = (fixed_beats > 0) ? fixed_beats : $urandom_range(1, 4);
    m_left[k]  = m_total[k];
    m_adr[k]   = $urandom & 32'hFFFF_FFFC;
    m_wdat[k]  = $urandom;
    m_we[k]    = 1'($urandom_range(0, 1));
    wbm_adr_i[k*32 +: 32] = m_adr[k];
    wbm_dat_i[k*32 +: 32] = m_wdat[k];
    wbm_sel_i[k*4 +: 4]   = 4'hF;
    wbm_bte_i[k*2 +: 2]   = 2'b00;
    wbm_we_i[k]           = m_we[k];
    drive_master(k, 1'b1);
  endtask

  task automatic do_reset();
    idle_masters();
    wbs_ack_i = 1'b0;
    wb_rst_n  = 1'b0;
    tick();
    tick();
    wb_rst_n  = 1'b1;
    last_m    = N - 1;
  endtask

  // Model: pending requesters are served in rotation order after the previous winner,
  // each grant preceded by exactly one idle cycle.
  task automatic run_round(input logic [N-1:0] mask, input int fixed_beats,
                           input bit full_ack, input logic [N-1:0] rereq_in);
    logic [N-1:0] pend, rereq, drop_prev;
    int owner, gap, waitn, budget, nxt;
    bit ak;
    pend = mask; rereq = rereq_in; drop_prev = '0;
    owner = -1; gap = 0; waitn = 0; budget = 400;
    for (int k = 0; k < N; k++) if (mask[k]) launch(k, fixed_beats);
    while ((pend != '0 || owner != -1) && budget > 0) begin
      budget--;
      wbs_dat_i = $urandom;
      wbs_ack_i = 1'b0;
      #1;
      ak = wbs_stb_o && (full_ack || waitn >= 3 || $urandom_range(0, 3) != 0);
      wbs_ack_i = ak;
      #1;
      if (arb_grant_o == '0) begin
        owner = -1;
        gap++;
        check("idle_wbs_cyc", wbs_cyc_o, 0);
      end else if (owner == -1) begin
        nxt = -1;
        for (int i = 1; i <= N; i++)
          if (nxt < 0 && pend[(last_m + i) % N]) nxt = (last_m + i) % N;
        check("gap_before_grant", gap, 1);
        if (nxt < 0) begin
          check("spurious_grant", arb_grant_o, 0);
          budget = 0;
        end else begin
          owner = nxt; pend[nxt] = 1'b0; last_m = nxt; gap = 0; waitn = 0;
        end
      end
      if (owner >= 0) begin
        check("grant", arb_grant_o, 64'd1 << owner);
        check("ack", wbm_ack_o, ak ? (64'd1 << owner) : 64'd0);
        check("err", wbm_err_o, 0);
        check("rty", wbm_rty_o, 0);
        if (wbm_stb_i[owner]) begin
          check("adr", wbs_adr_o, m_adr[owner]);
          check("wdat", wbs_dat_o, m_wdat[owner]);
          check("cti", wbs_cti_o, exp_cti(owner));
          check("we", wbs_we_o, m_we[owner]);
        end
        if (ak) begin
          check("rdata", wbm_dat_o, wbs_dat_i);
          m_left[owner]--;
          waitn = 0;
        end else begin
          waitn++;
        end
      end
      tick();
      for (int k = 0; k < N; k++) begin
        if (drop_prev[k]) begin
          drop_prev[k] = 1'b0;
          if (rereq[k]) begin
            rereq[k] = 1'b0;
            launch(k, fixed_beats);
            pend[k] = 1'b1;
          end
        end
      end
      if (owner >= 0 && wbm_cyc_i[owner]) begin
        if (m_left[owner] == 0) begin
          drive_master(owner, 1'b0);
          drop_prev[owner] = 1'b1;
        end else begin
          wbm_cti_i[owner*3 +: 3] = exp_cti(owner);
        end
      end
    end
    check("round_complete", (pend == '0 && owner == -1), 1);
    wbs_ack_i = 1'b0;
  endtask

  initial begin
    logic [N-1:0] mask;
    wb_rst_n = 1'b0;
    idle_masters();
    wbs_ack_i = 1'b0;
    wbs_dat_i = '0;
    last_m    = N - 1;
    tick();
    tick();
    check("rst_grant", arb_grant_o, 0);
    check("rst_timeout", arb_timeout_o, 0);
    check("rst_ack_err_rty", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
    check("rst_wbs_adr_dat", {wbs_adr_o, wbs_dat_o}, 0);
    check("rst_wbs_ctl", {wbs_sel_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o, wbs_we_o}, 0);
    wb_rst_n = 1'b1;
    tick();

    // single master 1, 4-beat incrementing burst acked every cycle
    run_round(3'b010, 4, 1'b1, 3'b000);

    // three-way contention after reset: 0, 1, 2
    do_reset();
    run_round(3'b111, 1, 1'b1, 3'b000);

    // master 0 re-requests in the idle cycle after its release while 2 waits
    do_reset();
    run_round(3'b101, 1, 1'b1, 3'b001);

    // watchdog: slave never acks
    do_reset();
    launch(1, 1);
    tick();
    for (int i = 1; i <= TO; i++) begin
      check("to_grant", arb_grant_o, 3'b010);
      check("to_wbs_cyc", wbs_cyc_o, 1);
      check("to_err", wbm_err_o, (i == TO) ? 3'b010 : 3'b000);
      check("to_pulse", arb_timeout_o, (i == TO));
      tick();
    end
    wbs_ack_i = 1'b1;
    #1;
    check("abort_wbs_cyc", wbs_cyc_o, 0);
    check("abort_wbs_stb", wbs_stb_o, 0);
    check("abort_ack", wbm_ack_o, 0);
    check("abort_err", wbm_err_o, 0);
    check("abort_pulse", arb_timeout_o, 0);
    check("abort_grant", arb_grant_o, 3'b010);
    wbs_ack_i = 1'b0;
    tick();
    drive_master(1, 1'b0);
    #1;
    check("abort_hold_grant", arb_grant_o, 3'b010);
    tick();
    check("abort_to_idle", arb_grant_o, 0);

    // ack exactly on the 8th stalled cycle wins over the watchdog and clears it
    do_reset();
    launch(1, 2);
    tick();
    for (int i = 1; i <= TO; i++) begin
      wbs_ack_i = (i == TO);
      #1;
      check("bnd_ack", wbm_ack_o, (i == TO) ? 3'b010 : 3'b000);
      check("bnd_err", wbm_err_o, 0);
      check("bnd_pulse", arb_timeout_o, 0);
      tick();
    end
    wbs_ack_i = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      #1;
      check("bnd_restart_err", wbm_err_o, (i == TO) ? 3'b010 : 3'b000);
      tick();
    end
    drive_master(1, 1'b0);
    tick();
    check("bnd_idle", arb_grant_o, 0);

    // reset during beat 2 of a master-2 burst
    do_reset();
    launch(2, 4);
    tick();
    wbs_ack_i = 1'b1;
    #1;
    check("mid_beat1_ack", wbm_ack_o, 3'b100);
    tick();
    wb_rst_n = 1'b0;
    #1;
    check("mid_beat2_ack", wbm_ack_o, 3'b100);
    tick();
    check("mid_rst_grant", arb_grant_o, 0);
    check("mid_rst_ack_err", {wbm_ack_o, wbm_err_o}, 0);
    check("mid_rst_wbs", {wbs_cyc_o, wbs_stb_o, wbs_adr_o}, 0);
    check("mid_rst_pulse", arb_timeout_o, 0);
    wb_rst_n  = 1'b1;
    wbs_ack_i = 1'b0;
    idle_masters();
    last_m = N - 1;
    tick();
    run_round(3'b111, 1, 1'b1, 3'b000);

    // randomized rounds: random requester sets, burst lengths, ack stalls and re-requests
    repeat (30) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      run_round(mask, 0, 1'b0, mask & N'($urandom_range(0, (1 << N) - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
